// File: rtl/ones_gen_pkg.sv
// ones_gen_pkg
//   Shared types and defaults for the ones-pattern generator.
//   - ones_gen_state_t : control FSM states (S1 idle, S2 build, S3 done)
//   - ONES_W / ONES_CW : default pattern width and count width
package ones_gen_pkg;

    localparam int ONES_W  = 8;
    localparam int ONES_CW = $clog2(ONES_W + 1);

    typedef enum logic [1:0] {
        S1 = 2'b00,   // idle: continuously load count, clear pattern
        S2 = 2'b01,   // build: shift one '1' in per cycle
        S3 = 2'b10    // done: hold pattern until start drops
    } ones_gen_state_t;

endpackage

// File: rtl/ones_gen_datapath.sv
// ones_gen_datapath
//   Count register, pattern shift register and clamp logic for the
//   ones-pattern generator. The controller drives two enables.
//   Optional: `define ONES_GEN_SAT_FLAG_EN adds the err_q saturation flag.
// Ports
//   clk         in   clock
//   reset       in   async active-low reset
//   load_data_i in   load cnt <= min(count_i, W), pattern <= 0
//   shift_dec_i in   shift a '1' into pattern LSB, cnt <= cnt-1
//   count_i     in   requested number of ones
//   pattern_o   out  current pattern register
//   cnt_eq_0_o  out  remaining count is zero
//   err_q_o     out  last load was clamped (macro only)
module ones_gen_datapath
    import ones_gen_pkg::*;
#(
    parameter int W  = ONES_W,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_data_i,
    input  logic          shift_dec_i,
    input  logic [CW-1:0] count_i,
    output logic [W-1:0]  pattern_o,
    output logic          cnt_eq_0_o
`ifdef ONES_GEN_SAT_FLAG_EN
   ,output logic          err_q_o
`endif
);

    localparam logic [CW-1:0] W_CNT = CW'(W);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  pattern_q, pattern_d;
    logic          over_w;
    logic [CW-1:0] cnt_clamped;

    // Requests above W saturate so the pattern never wraps.
    assign over_w      = (count_i > W_CNT);
    assign cnt_clamped = over_w ? W_CNT : count_i;
    assign cnt_eq_0_o  = (cnt_q == '0);
    assign pattern_o   = pattern_q;

    always_comb begin
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        if (load_data_i) begin
            cnt_d     = cnt_clamped;
            pattern_d = '0;
        end else if (shift_dec_i) begin
            cnt_d     = cnt_q - CW'(1);
            pattern_d = {pattern_q[W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            pattern_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
        end
    end

`ifdef ONES_GEN_SAT_FLAG_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           err_q <= 1'b0;
        else if (load_data_i) err_q <= over_w;
    end

    assign err_q_o = err_q;
`endif

endmodule

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen
//   Builds a W-bit word holding N ones (LSB-justified), one shift per
//   cycle, under a start/done handshake. Control FSM lives here; the
//   datapath is ones_gen_datapath.
//   Optional: `define ONES_GEN_SAT_FLAG_EN adds the err output.
// Ports
//   clk      in   clock
//   reset    in   async active-low reset
//   start    in   level handshake: high starts job, low releases done
//   count_in in   requested number of ones, sampled while idle
//   pattern  out  generated word, valid while done=1
//   done     out  high in S3 only
//   err      out  clamp happened on this job (macro only)
module ones_pattern_gen
    import ones_gen_pkg::*;
#(
    parameter int W  = ONES_W,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] count_in,
    output logic [W-1:0]  pattern,
    output logic          done
`ifdef ONES_GEN_SAT_FLAG_EN
   ,output logic          err
`endif
);

    ones_gen_state_t ps_q, ps_d;
    logic            load_data;
    logic            shift_dec;
    logic            cnt_eq_0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ps_q <= S1;
        else        ps_q <= ps_d;
    end

    // Enables are Mealy on ps/start/cnt_eq_0; done is Moore on ps only.
    always_comb begin
        ps_d      = ps_q;
        load_data = 1'b0;
        shift_dec = 1'b0;
        case (ps_q)
            S1: begin
                // The load is suppressed on the edge that leaves idle.
                if (start) ps_d = S2;
                else       load_data = 1'b1;
            end
            S2: begin
                if (cnt_eq_0) ps_d = S3;
                else          shift_dec = 1'b1;
            end
            S3: begin
                if (!start) ps_d = S1;
            end
            default: begin
                // Unused encoding recovers to idle with a fresh load.
                ps_d      = S1;
                load_data = 1'b1;
            end
        endcase
    end

    assign done = (ps_q == S3);

`ifdef ONES_GEN_SAT_FLAG_EN
    logic err_q;
`endif

    ones_gen_datapath #(
        .W  (W),
        .CW (CW)
    ) u_dp (
        .clk         (clk),
        .reset       (reset),
        .load_data_i (load_data),
        .shift_dec_i (shift_dec),
        .count_i     (count_in),
        .pattern_o   (pattern),
        .cnt_eq_0_o  (cnt_eq_0)
`ifdef ONES_GEN_SAT_FLAG_EN
       ,.err_q_o     (err_q)
`endif
    );

`ifdef ONES_GEN_SAT_FLAG_EN
    assign err = err_q & done;
`endif

endmodule

// File: tb/tb_ones_pattern_gen.sv
module tb_ones_pattern_gen;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          start;
    logic [CW-1:0] count_in;
    logic [W-1:0]  pattern;
    logic          done;
`ifdef ONES_GEN_SAT_FLAG_EN
    logic          err;
`endif

    int passed = 0;
    int total  = 0;

    ones_pattern_gen #(.W(W), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .count_in (count_in),
        .pattern  (pattern),
        .done     (done)
`ifdef ONES_GEN_SAT_FLAG_EN
       ,.err      (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: N ones at the bottom, N saturating at W.
    function automatic int clampn(input int n);
        return (n > W) ? W : n;
    endfunction

    function automatic logic [31:0] model_pattern(input int n);
        logic [31:0] one;
        one = 32'd1;
        return (one << clampn(n)) - 32'd1;
    endfunction

    // Runs one job from idle. mid >= 0 changes count_in two cycles into the build.
    task automatic run_job(input string tag, input int n, input int mid, input int hold);
        int k;
        logic [W-1:0] held;
        count_in = CW'(n);
        start    = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            if (done) break;
            if (k == 2 && mid >= 0) count_in = CW'(mid);
        end
        check({tag, "_lat"}, k, clampn(n) + 2);
        check({tag, "_pat"}, 32'(pattern), model_pattern(n));
        check({tag, "_pop"}, $countones(pattern), clampn(n));
`ifdef ONES_GEN_SAT_FLAG_EN
        check({tag, "_err"}, 32'(err), (n > W) ? 1 : 0);
`endif
        held = pattern;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            check({tag, "_hold_done"}, 32'(done), 1);
            check({tag, "_hold_pat"}, 32'(pattern), 32'(held));
        end
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_rel_done"}, 32'(done), 0);
        check({tag, "_rel_ps"}, 32'(dut.ps_q), 0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        count_in = '0;
        #12;
        check("rst_pat", 32'(pattern), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ps", 32'(dut.ps_q), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Async reset in the middle of a build.
        count_in = 4'd7;
        @(posedge clk); #1;
        start = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_pat", 32'(pattern), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_ps", 32'(dut.ps_q), 0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_hold_done", 32'(done), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_job("n3", 3, -1, 0);
        run_job("n0", 0, -1, 0);
        run_job("n8", 8, -1, 0);
        run_job("n12", 12, -1, 0);
        run_job("n15", 15, -1, 1);
        run_job("hold", 4, -1, 5);
        run_job("midchg", 6, 5, 2);

        for (int n = 0; n <= W; n++) run_job($sformatf("loop%0d", n), n, -1, 0);

        for (int i = 0; i < 20; i++)
            run_job($sformatf("rnd%0d", i), int'($urandom_range(0, 15)),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1,
                    int'($urandom_range(0, 3)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
